npu_host_seq: RTL and testbench

Host-side bus master that drives the NPU's memory-mapped slave port (ena/wea/addra/dina/douta). It executes a queued stream of commands: register writes, single reads, status polls and timed waits. Firmware or a testbench no longer has to hand-toggle the port cycle by cycle. It sits between the system controller (command producer) and the NPU register interface.

---
 rtl/npu_host_seq_if.sv | 36 +++
 rtl/npu_host_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_npu_host_seq.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_host_seq_if.sv
// npu_host_seq_if: command, response and NPU port bundle.
// master = sequencer side; slave = command producer plus NPU.
interface npu_host_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr,
        input  cmd_data, cmd_mask, douta,
        output cmd_ready, ena, wea, addra, dina,
        output rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr,
        output cmd_data, cmd_mask, douta,
        input  cmd_ready, ena, wea, addra, dina,
        input  rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/npu_host_seq.sv
// npu_host_seq: queued WRITE/READ/POLL/WAIT master for the NPU port.
// Define NPU_HOST_POLL_TIMEOUT_EN to bound POLL retries (rsp_err).
module npu_host_seq #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int POLL_TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    npu_host_seq_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_WAIT = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_RGAP, S_CHECK, S_WAIT
    } state_e;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
    } cmd_t;

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_nx;
    logic          full, empty, push, pop;
    cmd_t          head, cur;

    state_e        state, state_nx;
    logic [15:0]   wcnt;
    logic          match, poll_to;

    logic              ena_q, wea_q, rv_q, err_q, busy_q;
    logic [ADDR_W-1:0] addra_q;
    logic [DATA_W-1:0] dina_q, rsp_data_q;
    logic              ena_d, wea_d, rv_d, err_d;
    logic [ADDR_W-1:0] addra_d;
    logic [DATA_W-1:0] dina_d;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = bus.cmd_valid && !full;
    assign pop   = (state == S_IDLE) && !empty;
    assign head  = mem[rptr];

    assign bus.cmd_ready = !full;
    assign bus.ena       = ena_q;
    assign bus.wea       = wea_q;
    assign bus.addra     = addra_q;
    assign bus.dina      = dina_q;
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = busy_q;

    // Masked POLL compare against the word the NPU returns in RGAP.
    assign match = ((bus.douta ^ cur.data) & cur.mask) == '0;

`ifdef NPU_HOST_POLL_TIMEOUT_EN
    localparam int PW = $clog2(POLL_TIMEOUT + 1);
    logic [PW-1:0] pcnt;

    // Read strobes issued by the current POLL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (pop) begin
            pcnt <= '0;
        end else if (state == S_RD) begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign poll_to = (pcnt == PW'(POLL_TIMEOUT));
`else
    // Unbounded: POLL retries until it matches.
    assign poll_to = (POLL_TIMEOUT < 0);
`endif

    // Command storage; entries need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{
                op:   bus.cmd_op,
                addr: bus.cmd_addr,
                data: bus.cmd_data,
                mask: bus.cmd_mask
            };
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nx = count;
        case ({push, pop})
            2'b10:   count_nx = count + CNT_ONE;
            2'b01:   count_nx = count - CNT_ONE;
            default: count_nx = count;
        endcase
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count_nx;
        end
    end

    // Next state and next registered port values.
    always_comb begin
        state_nx = state;
        ena_d    = 1'b0;
        wea_d    = 1'b0;
        addra_d  = addra_q;
        dina_d   = dina_q;
        rv_d     = 1'b0;
        err_d    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    unique case (1'b1)
                        head.op == OP_WR: begin
                            state_nx = S_WR;
                            ena_d    = 1'b1;
                            wea_d    = 1'b1;
                            addra_d  = head.addr;
                            dina_d   = head.data;
                        end
                        head.op == OP_RD,
                        head.op == OP_POLL: begin
                            state_nx = S_RD;
                            ena_d    = 1'b1;
                            addra_d  = head.addr;
                        end
                        head.op == OP_WAIT: begin
                            if (head.data[15:0] != '0)
                                state_nx = S_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            S_WR:   state_nx = S_IDLE;
            S_RD:   state_nx = S_RGAP;
            S_RGAP: begin
                state_nx = S_CHECK;
                if (cur.op == OP_RD || match) begin
                    rv_d = 1'b1;
                end else if (poll_to) begin
                    rv_d  = 1'b1;
                    err_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (rv_q) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_RD;
                    ena_d    = 1'b1;
                    addra_d  = cur.addr;
                end
            end
            S_WAIT: begin
                if (wcnt == 16'd1)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, latched command, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cur        <= '0;
            wcnt       <= '0;
            ena_q      <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            rv_q       <= 1'b0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state   <= state_nx;
            ena_q   <= ena_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            busy_q  <= (count_nx != '0) || (state_nx != S_IDLE);
            if (pop) begin
                cur  <= head;
                wcnt <= head.data[15:0];
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 16'd1;
            end
            if (state == S_RGAP)
                rsp_data_q <= bus.douta;
        end
    end
endmodule

// File: tb/tb_npu_host_seq.sv
// tb_npu_host_seq: directed bench for npu_host_seq.
// NPU model answers reads; a logger records strobes and responses.
module tb_npu_host_seq;
    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;
    localparam logic [1:0] OP_WAIT = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    npu_host_seq_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    npu_host_seq #(
        .ADDR_W(16),
        .DATA_W(32),
        .FIFO_DEPTH(8),
        .POLL_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // NPU model: registers read data on the strobe edge.
    int poll_n = 0;
    int poll_hit_at = 0;
    always @(posedge clk) begin
        if (bus.ena === 1'b1 && bus.wea === 1'b0) begin
            if (bus.addra == 16'h7004) begin
                bus.douta <= 32'hFFFF_FF85;
            end else if (bus.addra == 16'h7000) begin
                bus.douta <= (poll_n >= poll_hit_at) ? 32'd1 : 32'd0;
                poll_n <= poll_n + 1;
            end else begin
                bus.douta <= {16'hDEAD, bus.addra};
            end
        end
    end

    typedef struct {
        int          cyc;
        logic        wea;
        logic [15:0] a;
        logic [31:0] d;
    } strb_t;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        err;
    } rsp_t;

    strb_t sq[$];
    rsp_t  rq[$];

    // Log every strobe cycle and response pulse.
    always @(negedge clk) begin
        if (bus.ena === 1'b1)
            sq.push_back('{cyc, bus.wea, bus.addra, bus.dina});
        if (bus.rsp_valid === 1'b1)
            rq.push_back('{cyc, bus.rsp_data, bus.rsp_err});
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Offer one command from a negedge; returns at a negedge
    // after acceptance with pc = cycle in which it was taken.
    task automatic push(input logic [1:0] op,
                        input logic [15:0] a,
                        input logic [31:0] d,
                        input logic [31:0] m,
                        output int pc);
        int g;
        g = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_mask  = m;
        while (bus.cmd_ready !== 1'b1 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("push_ready_wait", (g < 1000), 1);
        pc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int b, rb, pc, pw, p0, p9, n, g;
        int pcs[8];
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_mask  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ena", bus.ena, 0);
        chk("rst_wea", bus.wea, 0);
        chk("rst_addra", bus.addra, 0);
        chk("rst_dina", bus.dina, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // WRITE: strobe two cycles after push, no response
        b  = sq.size();
        rb = rq.size();
        push(OP_WR, 16'h1000, 32'h0403_0201, 32'h0, pc);
        chk("wr_busy", bus.busy, 1);
        repeat (6) @(negedge clk);
        #1;
        chk("wr_count", sq.size() - b, 1);
        if (sq.size() > b) begin
            chk("wr_cyc", sq[b].cyc, pc + 2);
            chk("wr_wea", sq[b].wea, 1);
            chk("wr_addr", sq[b].a, 16'h1000);
            chk("wr_data", sq[b].d, 32'h0403_0201);
        end
        chk("wr_no_rsp", rq.size() - rb, 0);
        chk("wr_hold_addra", bus.addra, 16'h1000);
        chk("wr_hold_dina", bus.dina, 32'h0403_0201);
        chk("wr_idle_busy", bus.busy, 0);

        // READ: response two cycles after the strobe
        b  = sq.size();
        rb = rq.size();
        push(OP_RD, 16'h7004, 32'h0, 32'h0, pc);
        repeat (8) @(negedge clk);
        #1;
        chk("rd_count", sq.size() - b, 1);
        if (sq.size() > b) begin
            chk("rd_cyc", sq[b].cyc, pc + 2);
            chk("rd_wea", sq[b].wea, 0);
            chk("rd_addr", sq[b].a, 16'h7004);
        end
        chk("rd_rsp_count", rq.size() - rb, 1);
        if (rq.size() > rb) begin
            chk("rd_rsp_cyc", rq[rb].cyc, pc + 4);
            chk("rd_rsp_data", rq[rb].d, 32'hFFFF_FF85);
            chk("rd_rsp_err", rq[rb].err, 0);
        end
        chk("rd_data_hold", bus.rsp_data, 32'hFFFF_FF85);
        chk("rd_valid_low", bus.rsp_valid, 0);

        // POLL matching on the third read (0,0,1)
        poll_hit_at = poll_n + 2;
        b  = sq.size();
        rb = rq.size();
        push(OP_POLL, 16'h7000, 32'h1, 32'h1, pc);
        repeat (15) @(negedge clk);
        #1;
        chk("poll_count", sq.size() - b, 3);
        for (int i = 0; i < 3; i++) begin
            if (sq.size() > b + i) begin
                chk("poll_cyc", sq[b+i].cyc, pc + 2 + 3 * i);
                chk("poll_wea", sq[b+i].wea, 0);
            end
        end
        chk("poll_rsp_count", rq.size() - rb, 1);
        if (rq.size() > rb) begin
            chk("poll_rsp_cyc", rq[rb].cyc, pc + 10);
            chk("poll_rsp_data", rq[rb].d, 32'h1);
            chk("poll_rsp_err", rq[rb].err, 0);
        end

        // POLL that never matches, followed by a WRITE
        poll_hit_at = poll_n + 1000;
        b  = sq.size();
        rb = rq.size();
        push(OP_POLL, 16'h7000, 32'h1, 32'h1, pc);
        push(OP_WR, 16'h2000, 32'hA5A5_A5A5, 32'h0, pw);
        repeat (25) @(negedge clk);
        #1;
`ifdef NPU_HOST_POLL_TIMEOUT_EN
        chk("to_count", sq.size() - b, 5);
        for (int i = 0; i < 4; i++) begin
            if (sq.size() > b + i) begin
                chk("to_cyc", sq[b+i].cyc, pc + 2 + 3 * i);
                chk("to_wea", sq[b+i].wea, 0);
            end
        end
        if (sq.size() > b + 4) begin
            chk("to_wr_cyc", sq[b+4].cyc, pc + 15);
            chk("to_wr_wea", sq[b+4].wea, 1);
            chk("to_wr_addr", sq[b+4].a, 16'h2000);
            chk("to_wr_data", sq[b+4].d, 32'hA5A5_A5A5);
        end
        chk("to_rsp_count", rq.size() - rb, 1);
        if (rq.size() > rb) begin
            chk("to_rsp_cyc", rq[rb].cyc, pc + 13);
            chk("to_rsp_err", rq[rb].err, 1);
            chk("to_rsp_data", rq[rb].d, 0);
        end
`else
        chk("nto_more", (sq.size() - b) > 4, 1);
        for (int i = 0; i < 6; i++) begin
            if (sq.size() > b + i) begin
                chk("nto_cyc", sq[b+i].cyc, pc + 2 + 3 * i);
                chk("nto_wea", sq[b+i].wea, 0);
            end
        end
        chk("nto_no_rsp", rq.size() - rb, 0);
`endif
        do_reset();

        // WAIT 100 while 9 WRITEs are queued
        b = sq.size();
        push(OP_WAIT, 16'h0, 32'd100, 32'h0, p0);
        for (int i = 0; i < 8; i++)
            push(OP_WR, 16'h3000 + 16'(i), 32'h100 + i, 32'h0, pcs[i]);
        chk("full_ready", bus.cmd_ready, 0);
        chk("full_busy", bus.busy, 1);
        chk("full_8th_cyc", pcs[7], p0 + 8);
        push(OP_WR, 16'h3008, 32'h108, 32'h0, p9);
        chk("ninth_cyc", p9, p0 + 103);
        repeat (30) @(negedge clk);
        #1;
        chk("fifo_count", sq.size() - b, 9);
        for (int i = 0; i < 9; i++) begin
            if (sq.size() > b + i) begin
                chk("fifo_cyc", sq[b+i].cyc, p0 + 103 + 2 * i);
                chk("fifo_wea", sq[b+i].wea, 1);
                chk("fifo_addr", sq[b+i].a, 16'h3000 + i);
                chk("fifo_data", sq[b+i].d, 32'h100 + i);
            end
        end
        chk("fifo_idle_busy", bus.busy, 0);

        // Reset during the second POLL strobe, 3 WRITEs queued
        poll_hit_at = poll_n + 1000;
        b = sq.size();
        push(OP_POLL, 16'h7000, 32'h1, 32'h1, pc);
        push(OP_WR, 16'h4000, 32'h1, 32'h0, pw);
        push(OP_WR, 16'h4001, 32'h2, 32'h0, pw);
        push(OP_WR, 16'h4002, 32'h3, 32'h0, pw);
        g = 0;
        #1;
        while (sq.size() - b < 2 && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("mid_reach", sq.size() - b, 2);
        if (sq.size() > b + 1)
            chk("mid_s2_cyc", sq[b+1].cyc, pc + 5);
        chk("mid_ena_before", bus.ena, 1);
        rst = 1'b1;
        #1;
        chk("mid_ena", bus.ena, 0);
        chk("mid_wea", bus.wea, 0);
        chk("mid_addra", bus.addra, 0);
        chk("mid_dina", bus.dina, 0);
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_ready", bus.cmd_ready, 1);
        n = sq.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("post_no_strobe", sq.size() - n, 0);
        chk("post_busy", bus.busy, 0);
        chk("post_ready", bus.cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
